// File: rtl/me_frame_sequencer_if.sv
// Search request/acknowledge channel plus per-macroblock result stream.
// The frame sequencer is the master; the ME datapath and result sink form the slave.
interface me_frame_sequencer_if #(
    parameter int SAD_WIDTH  = 16,
    parameter int MVEC_WIDTH = 12,
    parameter int IDX_WIDTH  = 8
);
    logic                  me_req;
    logic                  me_ack;
    logic [SAD_WIDTH-1:0]  me_min_sad;
    logic [MVEC_WIDTH-1:0] me_min_mvec;
    logic                  res_valid;
    logic                  res_ready;
    logic [SAD_WIDTH-1:0]  res_sad;
    logic [MVEC_WIDTH-1:0] res_mvec;
    logic [IDX_WIDTH-1:0]  res_mb_x;
    logic [IDX_WIDTH-1:0]  res_mb_y;

    modport master (
        output me_req,
        input  me_ack,
        input  me_min_sad,
        input  me_min_mvec,
        output res_valid,
        input  res_ready,
        output res_sad,
        output res_mvec,
        output res_mb_x,
        output res_mb_y
    );

    modport slave (
        input  me_req,
        output me_ack,
        output me_min_sad,
        output me_min_mvec,
        input  res_valid,
        output res_ready,
        input  res_sad,
        input  res_mvec,
        input  res_mb_x,
        input  res_mb_y
    );
endinterface

// File: rtl/me_frame_sequencer.sv
// Four-phase req/ack initiator that walks a frame's macroblocks in raster order,
// streams each search result out and tracks the frame-wide minimum SAD.
module me_frame_sequencer #(
    parameter int SAD_WIDTH      = 16,
    parameter int MVEC_WIDTH     = 12,
    parameter int MB_COLS        = 4,
    parameter int MB_ROWS        = 4,
    parameter int IDX_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [IDX_WIDTH-1:0] mb_x,
    output logic [IDX_WIDTH-1:0] mb_y,
    output logic [SAD_WIDTH-1:0] frame_min_sad,
    output logic [IDX_WIDTH-1:0] frame_min_mb_x,
    output logic [IDX_WIDTH-1:0] frame_min_mb_y,
    me_frame_sequencer_if.master bus
);
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_X   = IDX_WIDTH'(MB_COLS - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_Y   = IDX_WIDTH'(MB_ROWS - 1);
    localparam logic [SAD_WIDTH-1:0] SAD_MAX  = {SAD_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_REQ     = 3'd2,
        S_RELEASE = 3'd3,
        S_FINISH  = 3'd4,
        S_ABORT   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  me_req_q, me_req_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [IDX_WIDTH-1:0]  mb_x_q, mb_x_d;
    logic [IDX_WIDTH-1:0]  mb_y_q, mb_y_d;
    logic                  res_valid_q, res_valid_d;
    logic [SAD_WIDTH-1:0]  res_sad_q, res_sad_d;
    logic [MVEC_WIDTH-1:0] res_mvec_q, res_mvec_d;
    logic [IDX_WIDTH-1:0]  res_mb_x_q, res_mb_x_d;
    logic [IDX_WIDTH-1:0]  res_mb_y_q, res_mb_y_d;
    logic [SAD_WIDTH-1:0]  fmin_sad_q, fmin_sad_d;
    logic [IDX_WIDTH-1:0]  fmin_x_q, fmin_x_d;
    logic [IDX_WIDTH-1:0]  fmin_y_q, fmin_y_d;
    logic                  capture_s;

    // Next-state, macroblock walk, result capture and frame-minimum tracking.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = err_q;
        mb_x_d      = mb_x_q;
        mb_y_d      = mb_y_q;
        fmin_sad_d  = fmin_sad_q;
        fmin_x_d    = fmin_x_q;
        fmin_y_d    = fmin_y_q;
        capture_s   = 1'b0;
        res_valid_d = res_valid_q;
        res_sad_d   = res_sad_q;
        res_mvec_d  = res_mvec_q;
        res_mb_x_d  = res_mb_x_q;
        res_mb_y_d  = res_mb_y_q;

        case (state_q)
            S_IDLE: begin
                // busy_q is still high during the done cycle, so a start there is dropped.
                if (start && !busy_q) begin
                    state_d    = S_SETUP;
                    mb_x_d     = '0;
                    mb_y_d     = '0;
                    err_d      = 1'b0;
                    fmin_sad_d = SAD_MAX;
                    fmin_x_d   = '0;
                    fmin_y_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                cnt_d = '0;
                if (!bus.me_ack && (!res_valid_q || bus.res_ready)) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_SETUP;
                end
            end
            S_REQ: begin
                if (bus.me_ack) begin
                    capture_s = 1'b1;
                    state_d   = S_RELEASE;
                    if (bus.me_min_sad < fmin_sad_q) begin
                        fmin_sad_d = bus.me_min_sad;
                        fmin_x_d   = mb_x_q;
                        fmin_y_d   = mb_y_q;
                    end else begin
                        fmin_sad_d = fmin_sad_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_RELEASE: begin
                if (!bus.me_ack) begin
                    if (mb_x_q == LAST_X && mb_y_q == LAST_Y) begin
                        state_d = S_FINISH;
                    end else if (mb_x_q == LAST_X) begin
                        state_d = S_SETUP;
                        mb_x_d  = '0;
                        mb_y_d  = mb_y_q + IDX_WIDTH'(1);
                    end else begin
                        state_d = S_SETUP;
                        mb_x_d  = mb_x_q + IDX_WIDTH'(1);
                    end
                end else begin
                    state_d = S_RELEASE;
                end
            end
            S_FINISH: begin
                if (!res_valid_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_ABORT: begin
                if (!bus.me_ack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ABORT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A capture wins over a same-edge consume: the new result stays valid.
        if (capture_s) begin
            res_valid_d = 1'b1;
            res_sad_d   = bus.me_min_sad;
            res_mvec_d  = bus.me_min_mvec;
            res_mb_x_d  = mb_x_q;
            res_mb_y_d  = mb_y_q;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end

        me_req_d = (state_d == S_REQ);
        busy_d   = (state_d != S_IDLE) || done_d;
    end

    // State and output registers; me_req and everything else clear asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            me_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mb_x_q      <= '0;
            mb_y_q      <= '0;
            res_valid_q <= 1'b0;
            res_sad_q   <= '0;
            res_mvec_q  <= '0;
            res_mb_x_q  <= '0;
            res_mb_y_q  <= '0;
            fmin_sad_q  <= SAD_MAX;
            fmin_x_q    <= '0;
            fmin_y_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            me_req_q    <= me_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mb_x_q      <= mb_x_d;
            mb_y_q      <= mb_y_d;
            res_valid_q <= res_valid_d;
            res_sad_q   <= res_sad_d;
            res_mvec_q  <= res_mvec_d;
            res_mb_x_q  <= res_mb_x_d;
            res_mb_y_q  <= res_mb_y_d;
            fmin_sad_q  <= fmin_sad_d;
            fmin_x_q    <= fmin_x_d;
            fmin_y_q    <= fmin_y_d;
        end
    end

    assign bus.me_req     = me_req_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_sad    = res_sad_q;
    assign bus.res_mvec   = res_mvec_q;
    assign bus.res_mb_x   = res_mb_x_q;
    assign bus.res_mb_y   = res_mb_y_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign mb_x           = mb_x_q;
    assign mb_y           = mb_y_q;
    assign frame_min_sad  = fmin_sad_q;
    assign frame_min_mb_x = fmin_x_q;
    assign frame_min_mb_y = fmin_y_q;
endmodule
